// File: rtl/radar_echo_emulator.sv
// Purpose : emulates a point-target radar echo by delaying each transmit trigger edge.
// Latency : echo rises cur_delay cycles after the trigger edge and stays high ECHO_WIDTH cycles.
// Backpr. : none; trigger edges arriving while a pulse is in flight are dropped and flagged.
//
// Ports
//   CLK                 single clock, 1 cycle = 1 us, rising edge
//   RST                 asynchronous active-high reset
//   radar_pulse_trigger transmitter trigger level; a rising edge starts a pulse
//   target_present      high while the emulated target is in range
//   load                one-cycle strobe that loads echo_delay into the delay register
//   echo_delay          new round-trip delay in cycles (150 m per cycle)
//   closing_rate        cycles removed from the delay after every completed echo
//   radar_echo          emulated echo, registered
//   emu_state           0 IDLE, 1 WAIT, 2 ECHO
//   echo_count          completed echoes, saturating at 255
//   missed_pulse        sticky: a trigger edge arrived while busy
module radar_echo_emulator #(
    parameter int ECHO_WIDTH  = 10,
    parameter int MIN_DELAY   = 2,
    parameter int RESET_DELAY = 100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        radar_pulse_trigger,
    input  logic        target_present,
    input  logic        load,
    input  logic [15:0] echo_delay,
    input  logic [7:0]  closing_rate,
    output logic        radar_echo,
    output logic [1:0]  emu_state,
    output logic [7:0]  echo_count,
    output logic        missed_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ECHO = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam logic [15:0] MIN_D     = 16'(MIN_DELAY);
    localparam logic [15:0] RST_D     = 16'(RESET_DELAY);
    // ECHO counts down to zero, so it is preloaded with one less than the width.
    localparam logic [15:0] ECHO_LAST = 16'(ECHO_WIDTH - 1);

    state_t      state;
    logic [15:0] counter;
    logic [15:0] cur_delay;
    logic        trig_prev;
    // trig_armed stays low after reset until the trigger has been seen low once,
    // so a trigger that was already high across reset release is not an edge.
    logic        trig_armed;
    logic        trig_rise;

    logic [16:0] closed_delay;
    logic [15:0] next_closed;
    logic [15:0] load_delay;

    assign trig_rise = radar_pulse_trigger & ~trig_prev & trig_armed;

    // Closing update done one bit wider so a large closing_rate cannot wrap.
    assign closed_delay = {1'b0, cur_delay} - {9'd0, closing_rate};

    always_comb begin
        next_closed = closed_delay[15:0];
        if (closed_delay[16] || (closed_delay[15:0] < MIN_D)) begin
            next_closed = MIN_D;
        end
    end

    assign load_delay = (echo_delay < MIN_D) ? MIN_D : echo_delay;

    // state itself is a register, so the exported state is registered too.
    assign emu_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            counter      <= 16'd0;
            cur_delay    <= RST_D;
            trig_prev    <= 1'b0;
            trig_armed   <= 1'b0;
            radar_echo   <= 1'b0;
            echo_count   <= 8'd0;
            missed_pulse <= 1'b0;
        end else begin
            trig_prev <= radar_pulse_trigger;
            if (!radar_pulse_trigger) begin
                trig_armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    radar_echo <= 1'b0;
                    // With no target the edge is simply consumed: no echo, no flag.
                    if (trig_rise && target_present) begin
                        state   <= ST_WAIT;
                        counter <= cur_delay;
                    end
                end

                ST_WAIT: begin
                    if (trig_rise) begin
                        missed_pulse <= 1'b1;
                    end
                    if (!target_present) begin
                        // Target left range: abandon this pulse, delay untouched.
                        state   <= ST_IDLE;
                        counter <= 16'd0;
                    end else if (counter <= 16'd1) begin
                        // Counter was loaded with cur_delay at the edge, so the
                        // echo rises exactly cur_delay edges after it.
                        state      <= ST_ECHO;
                        radar_echo <= 1'b1;
                        counter    <= ECHO_LAST;
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end

                ST_ECHO: begin
                    // Target loss here is ignored: the echo already left the target.
                    if (trig_rise) begin
                        missed_pulse <= 1'b1;
                    end
                    if (counter == 16'd0) begin
                        state      <= ST_IDLE;
                        radar_echo <= 1'b0;
                        cur_delay  <= next_closed;
                        if (echo_count != 8'hFF) begin
                            echo_count <= echo_count + 8'd1;
                        end
                    end else begin
                        counter <= counter - 16'd1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    radar_echo <= 1'b0;
                    counter    <= 16'd0;
                end
            endcase

            // Placed after the case so an explicit load overrides the closing update.
            if (load) begin
                cur_delay <= load_delay;
            end
        end
    end

endmodule

// File: tb/tb_radar_echo_emulator.sv
// Purpose : scoreboard bench for radar_echo_emulator against an event-time reference model.
// Latency : expected echoes are queued when the model completes them and popped on echo fall.
// Backpr. : none; every wait on the DUT is bounded by a cycle budget.
module tb_radar_echo_emulator;

    localparam int W     = 10;
    localparam int MIN_D = 2;
    localparam int RST_D = 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        trig = 1'b0;
    logic        target = 1'b0;
    logic        load = 1'b0;
    logic [15:0] echo_delay = 16'd0;
    logic [7:0]  closing_rate = 8'd0;
    logic        radar_echo;
    logic [1:0]  emu_state;
    logic [7:0]  echo_count;
    logic        missed_pulse;

    radar_echo_emulator #(
        .ECHO_WIDTH (W),
        .MIN_DELAY  (MIN_D),
        .RESET_DELAY(RST_D)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .radar_pulse_trigger(trig),
        .target_present     (target),
        .load               (load),
        .echo_delay         (echo_delay),
        .closing_rate       (closing_rate),
        .radar_echo         (radar_echo),
        .emu_state          (emu_state),
        .echo_count         (echo_count),
        .missed_pulse       (missed_pulse)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int start;
        int stop;
        int cnt;
    } echo_t;

    echo_t exp_q[$];

    // Reference model: a pulse is a pair of absolute times (start, end);
    // the model only tracks whether one is outstanding and compares times.
    int  cyc = 0;
    bit  m_have;
    int  m_start;
    int  m_end;
    int  m_delay = RST_D;
    int  m_count;
    int  m_missed;
    bit  m_prev;
    bit  m_armed;
    bit  exp_echo;
    int  exp_state;

    always @(posedge CLK) begin : model
        bit    rise;
        int    nd;
        echo_t e;
        cyc++;
        if (RST) begin
            m_have   = 0;
            m_delay  = RST_D;
            m_count  = 0;
            m_missed = 0;
            m_prev   = 0;
            m_armed  = 0;
        end else begin
            rise = trig && !m_prev && m_armed;
            if (!trig) m_armed = 1;
            m_prev = trig;
            nd = m_delay;
            if (m_have) begin
                if (rise) m_missed = 1;
                if (!target && cyc <= m_start) begin
                    m_have = 0;
                end else if (cyc == m_end) begin
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                    nd = m_delay - int'(closing_rate);
                    if (nd < MIN_D) nd = MIN_D;
                    e.start = m_start;
                    e.stop  = m_end;
                    e.cnt   = m_count;
                    exp_q.push_back(e);
                    m_have = 0;
                end
            end else if (rise && target) begin
                m_have  = 1;
                m_start = cyc + m_delay;
                m_end   = m_start + W;
            end
            if (load) nd = (int'(echo_delay) < MIN_D) ? MIN_D : int'(echo_delay);
            m_delay = nd;
        end
        exp_echo  = m_have && (cyc >= m_start);
        exp_state = !m_have ? 0 : ((cyc >= m_start) ? 2 : 1);
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: per-cycle level checks plus one queue pop per completed echo.
    initial begin : monitor
        bit    in_echo;
        int    obs_start;
        echo_t e;
        in_echo   = 0;
        obs_start = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                in_echo = 0;
            end else begin
                check("echo_level", radar_echo, exp_echo);
                check("state", emu_state, exp_state);
                check("count", echo_count, m_count);
                check("missed", missed_pulse, m_missed);
                if (radar_echo && !in_echo) begin
                    in_echo   = 1;
                    obs_start = cyc;
                end else if (!radar_echo && in_echo) begin
                    in_echo = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_echo: echo from cycle %0d to %0d, required none", obs_start, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("echo_start", obs_start, e.start);
                        check("echo_end", cyc, e.stop);
                        check("echo_count_at_end", echo_count, e.cnt);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input int d);
        echo_delay = 16'(d);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (emu_state != 2'd0 && n < max_cyc);
        total++;
        if (emu_state != 2'd0) begin
            bad++;
            $display("FAIL wait_idle: emu_state=%0d after %0d cycles, required 0", emu_state, max_cyc);
        end
    endtask

    task automatic pulse(input int wait_budget);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        wait_idle(wait_budget);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        RST = 1'b1;
        step(3);
        check("rst_echo", radar_echo, 0);
        check("rst_state", emu_state, 0);
        check("rst_count", echo_count, 0);
        check("rst_missed", missed_pulse, 0);
        RST = 1'b0;
        target = 1'b1;
        step(3);

        // Default delay after reset: echo at k+100..k+109.
        pulse(200);
        check("first_echo_count", echo_count, 1);

        // Closing target: offsets 5, 3, then clamped to 2.
        closing_rate = 8'd2;
        do_load(5);
        repeat (3) begin
            pulse(50);
            step(2);
        end
        check("closing_count", echo_count, 4);

        // Zero delay clamps to the minimum.
        closing_rate = 8'd0;
        do_load(0);
        pulse(50);
        step(2);

        // Second edge inside WAIT is dropped and flagged.
        do_load(20);
        trig = 1'b1;
        step(4);
        trig = 1'b0;
        step(1);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        wait_idle(100);
        check("missed_after_double", missed_pulse, 1);
        step(2);

        // Target lost 10 cycles into WAIT: no echo.
        do_load(30);
        trig = 1'b1;
        step(10);
        target = 1'b0;
        step(2);
        target = 1'b1;
        trig = 1'b0;
        wait_idle(100);
        check("drop_count", echo_count, 6);

        // No target at the edge: no echo and no flag.
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        target = 1'b0;
        step(2);
        trig = 1'b1;
        step(3);
        trig = 1'b0;
        step(3);
        check("notarget_missed", missed_pulse, 0);
        check("notarget_state", emu_state, 0);
        target = 1'b1;

        // Trigger held high gives one echo only.
        do_load(3);
        trig = 1'b1;
        step(60);
        trig = 1'b0;
        step(2);
        check("held_high_count", echo_count, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) trig = ~trig;
            target = ($urandom_range(0, 24) != 0);
            load = ($urandom_range(0, 30) == 0);
            echo_delay = 16'($urandom_range(0, 40));
            if ($urandom_range(0, 50) == 0) closing_rate = 8'($urandom_range(0, 60));
            step(1);
        end
        load = 1'b0;
        trig = 1'b0;
        target = 1'b1;
        wait_idle(200);
        step(2);

        // Asynchronous reset in the middle of an echo.
        closing_rate = 8'd0;
        do_load(4);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        n = 0;
        while (radar_echo !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("echo_before_reset", radar_echo, 1);
        step(3);
        RST = 1'b1;
        #1;
        check("async_rst_echo", radar_echo, 0);
        check("async_rst_count", echo_count, 0);
        check("async_rst_state", emu_state, 0);
        check("async_rst_missed", missed_pulse, 0);
        trig = 1'b1;
        step(2);
        RST = 1'b0;
        step(5);
        trig = 1'b0;
        step(3);
        check("held_through_reset_state", emu_state, 0);
        check("held_through_reset_count", echo_count, 0);

        // Saturation of the echo counter.
        do_load(2);
        repeat (255) pulse(50);
        check("count_255", echo_count, 255);
        pulse(50);
        check("count_saturated", echo_count, 255);

        step(3);
        check("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
